// File: rtl/mbi5353_frame_ctrl_if.sv
// Frame-buffer read port, request/handshake lines and driver pins of the
// MBI5353 frame controller, bundled so controller and environment share
// one definition.
//
// Handshake: start and cfg_req are single-cycle pulses with no ready; the
// controller always accepts them, either immediately in IDLE or by latching
// them as pending while busy. rd_en is a one-cycle read strobe and rd_data
// must hold the addressed word exactly one sys_clk after rd_en.
interface mbi5353_frame_ctrl_if #(
  parameter int AW = 8
);
  logic          start;
  logic          cfg_req;
  logic [15:0]   cfg_word;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [15:0]   rd_data;
  logic          dclk;
  logic          sdi;
  logic          le;
  logic          busy;
  logic          frame_done;
  logic [2:0]    state_dbg;

  // Controller side
  modport master (
    input  start, cfg_req, cfg_word, rd_data,
    output rd_addr, rd_en, dclk, sdi, le, busy, frame_done, state_dbg
  );

  // Environment side (frame buffer, host, pins)
  modport slave (
    output start, cfg_req, cfg_word, rd_data,
    input  rd_addr, rd_en, dclk, sdi, le, busy, frame_done, state_dbg
  );
endinterface

// File: rtl/mbi5353_frame_ctrl.sv
// MBI5353 serial-chain sequencer. Fetches gray words from the frame buffer,
// shifts them MSB first on a gated DCLK, terminates each channel with a
// data-latch LE, each frame with a VSYNC LE, and also issues config writes.
// Pins are decoded from registered state only, so an asynchronous reset
// drops them to 0 immediately.
module mbi5353_frame_ctrl #(
  parameter int CHAIN    = 4,
  parameter int CHANNELS = 16,
  parameter int HALF     = 4,
  parameter int DATA_LE  = 1,
  parameter int VSYNC_LE = 3,
  parameter int CFG_LE   = 4,
  parameter int AW       = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  mbi5353_frame_ctrl_if.master bus
);

  localparam int DW = (CHAIN > 1) ? $clog2(CHAIN) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int HW = $clog2(HALF);

  localparam logic [DW-1:0] DEV_LAST      = DW'(CHAIN - 1);
  localparam logic [CW-1:0] CH_LAST       = CW'(CHANNELS - 1);
  localparam logic [HW-1:0] HC_LAST       = HW'(HALF - 1);
  localparam logic [3:0]    BIT_LAST      = 4'd15;
  localparam logic [3:0]    GAP_LAST      = 4'd1;
  localparam logic [3:0]    VSYNC_LAST    = 4'(VSYNC_LE - 1);
  localparam logic [3:0]    DATA_LE_FIRST = 4'(16 - DATA_LE);
  localparam logic [3:0]    CFG_LE_FIRST  = 4'(16 - CFG_LE);
  localparam logic [AW-1:0] CHAIN_A       = AW'(CHAIN);
  localparam logic [AW-1:0] DEV_LAST_A    = AW'(CHAIN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    VSYNC = 3'd4,
    CFG   = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t        state;
  state_t        state_n;

  logic [HW-1:0] hc;          // sys_clk count within a DCLK half-period
  logic          ph;          // 0 = DCLK low half, 1 = DCLK high half
  logic [3:0]    bc;          // bit / period counter within the current state
  logic [DW-1:0] dev;         // device index (also config copy index)
  logic [CW-1:0] ch;          // channel index
  logic          fetch_ph;    // 0 = strobe cycle, 1 = capture cycle
  logic [15:0]   sreg;        // shift register, MSB is on sdi
  logic [15:0]   cfg_lat;     // config word reloaded for every copy
  logic          pend_start;
  logic          pend_cfg;
  logic [15:0]   pend_word;

  logic          active;
  logic          end_per;
  logic          cfg_go;
  logic          start_go;
  logic [15:0]   cfg_src;
  logic          acc_cfg;
  logic          acc_start;
  logic [AW-1:0] fetch_addr;

  // DCLK runs only in the states that clock bits out to the chain.
  assign active = (state == SHIFT) || (state == GAP) ||
                  (state == VSYNC) || (state == CFG);

  // Last sys_clk of a DCLK period: the falling transition follows it.
  assign end_per = ph && (hc == HC_LAST);

  // A pending config is older than a fresh cfg_req, so it wins.
  assign cfg_go    = pend_cfg || bus.cfg_req;
  assign cfg_src   = pend_cfg ? pend_word : bus.cfg_word;
  assign start_go  = pend_start || bus.start;
  assign acc_cfg   = (state == IDLE) && cfg_go;
  assign acc_start = (state == IDLE) && !cfg_go && start_go;

  // Farthest device in the chain is shifted first.
  assign fetch_addr = AW'(ch) * CHAIN_A + DEV_LAST_A - AW'(dev);

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_n;
  end

  // Next-state and pin decode
  always_comb begin
    state_n        = state;
    bus.dclk       = 1'b0;
    bus.sdi        = 1'b0;
    bus.le         = 1'b0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    bus.busy       = (state != IDLE);
    bus.frame_done = 1'b0;
    bus.state_dbg  = state;

    if (active) bus.dclk = ph;

    case (state)
      IDLE: begin
        if (cfg_go)        state_n = CFG;
        else if (start_go) state_n = FETCH;
      end
      FETCH: begin
        if (!fetch_ph) begin
          bus.rd_en   = 1'b1;
          bus.rd_addr = fetch_addr;
        end else begin
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        bus.sdi = sreg[15];
        bus.le  = (dev == DEV_LAST) && (bc >= DATA_LE_FIRST);
        if (end_per && (bc == BIT_LAST)) begin
          if ((dev == DEV_LAST) && (ch == CH_LAST)) state_n = GAP;
          else                                      state_n = FETCH;
        end
      end
      GAP: begin
        if (end_per && (bc == GAP_LAST)) state_n = VSYNC;
      end
      VSYNC: begin
        bus.le = 1'b1;
        if (end_per && (bc == VSYNC_LAST)) state_n = DONE;
      end
      CFG: begin
        bus.sdi = sreg[15];
        bus.le  = (dev == DEV_LAST) && (bc >= CFG_LE_FIRST);
        if (end_per && (bc == BIT_LAST) && (dev == DEV_LAST)) state_n = IDLE;
      end
      DONE: begin
        bus.frame_done = 1'b1;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // DCLK half-period timer; parks low whenever the clock is gated off.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hc <= '0;
      ph <= 1'b0;
    end else if (active) begin
      if (hc == HC_LAST) begin
        hc <= '0;
        ph <= ~ph;
      end else begin
        hc <= hc + 1'b1;
      end
    end else begin
      hc <= '0;
      ph <= 1'b0;
    end
  end

  // Word, bit, device and channel sequencing plus the shift register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bc       <= '0;
      dev      <= '0;
      ch       <= '0;
      fetch_ph <= 1'b0;
      sreg     <= '0;
      cfg_lat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          fetch_ph <= 1'b0;
          bc       <= '0;
          if (cfg_go) begin
            sreg    <= cfg_src;
            cfg_lat <= cfg_src;
            dev     <= '0;
          end else if (start_go) begin
            ch  <= '0;
            dev <= '0;
          end
        end
        FETCH: begin
          fetch_ph <= ~fetch_ph;
          if (fetch_ph) begin
            sreg <= bus.rd_data;
            bc   <= '0;
          end
        end
        SHIFT: begin
          if (end_per) begin
            if (bc == BIT_LAST) begin
              bc <= '0;
              if (dev == DEV_LAST) begin
                dev <= '0;
                ch  <= (ch == CH_LAST) ? '0 : ch + 1'b1;
              end else begin
                dev <= dev + 1'b1;
              end
            end else begin
              bc   <= bc + 1'b1;
              sreg <= {sreg[14:0], 1'b0};
            end
          end
        end
        GAP: begin
          if (end_per) bc <= (bc == GAP_LAST) ? '0 : bc + 1'b1;
        end
        VSYNC: begin
          if (end_per) bc <= (bc == VSYNC_LAST) ? '0 : bc + 1'b1;
        end
        CFG: begin
          if (end_per) begin
            if (bc == BIT_LAST) begin
              bc   <= '0;
              sreg <= cfg_lat;
              dev  <= (dev == DEV_LAST) ? '0 : dev + 1'b1;
            end else begin
              bc   <= bc + 1'b1;
              sreg <= {sreg[14:0], 1'b0};
            end
          end
        end
        default: begin
          fetch_ph <= 1'b0;
        end
      endcase
    end
  end

  // Pending requests: one start flag, one config slot; extras are dropped.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_start <= 1'b0;
      pend_cfg   <= 1'b0;
      pend_word  <= '0;
    end else begin
      if (acc_cfg) begin
        if (pend_cfg && bus.cfg_req) pend_word <= bus.cfg_word;
        else                         pend_cfg  <= 1'b0;
      end else if (bus.cfg_req && !pend_cfg) begin
        pend_cfg  <= 1'b1;
        pend_word <= bus.cfg_word;
      end

      if (acc_start)      pend_start <= 1'b0;
      else if (bus.start) pend_start <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mbi5353_frame_ctrl.sv
// Bench for mbi5353_frame_ctrl: directed and randomized frames/configs,
// checked against a per-DCLK-period model of the pin stream.
module tb_mbi5353_frame_ctrl;

  localparam int CHAIN     = 2;
  localparam int CHANNELS  = 2;
  localparam int HALF      = 2;
  localparam int DATA_LE   = 1;
  localparam int VSYNC_LE  = 3;
  localparam int CFG_LE    = 4;
  localparam int AW        = 8;
  localparam int FRAME_LEN = CHAIN*CHANNELS*(32*HALF + 2) + (2 + VSYNC_LE)*2*HALF + 1;
  localparam int BUDGET    = 5000;

  // ---------------- clock / reset ----------------
  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  mbi5353_frame_ctrl_if #(.AW(AW)) bus ();

  mbi5353_frame_ctrl #(
    .CHAIN(CHAIN), .CHANNELS(CHANNELS), .HALF(HALF), .DATA_LE(DATA_LE),
    .VSYNC_LE(VSYNC_LE), .CFG_LE(CFG_LE), .AW(AW)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [1:0]    exp_q[$];       // {sdi, le} per DCLK period
  logic [1:0]    got_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] addr_q[$];
  int            fd_cnt = 0;

  logic [15:0]   mem [256];
  logic          prev_dclk = 1'b0;
  logic          prev_sdi  = 1'b0;
  logic          prev_le   = 1'b0;
  logic          rd_pend   = 1'b0;
  logic [AW-1:0] rd_a      = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- frame buffer and pin monitor ----------------
  // Read data is only valid in the cycle after rd_en; otherwise it is noise.
  always @(negedge sys_clk) begin
    if (rd_pend) bus.rd_data = mem[rd_a];
    else         bus.rd_data = 16'($urandom);
    rd_pend = bus.rd_en;
    rd_a    = bus.rd_addr;
    if (bus.rd_en)      addr_q.push_back(bus.rd_addr);
    if (bus.frame_done) fd_cnt++;
    if (bus.dclk && !prev_dclk) got_q.push_back({bus.sdi, bus.le});
    if (bus.dclk && prev_dclk) begin
      check("sdi_hold", 32'(bus.sdi), 32'(prev_sdi));
      check("le_hold",  32'(bus.le),  32'(prev_le));
    end
    prev_dclk = bus.dclk;
    prev_sdi  = bus.sdi;
    prev_le   = bus.le;
  end

  // ---------------- reference model ----------------
  task automatic model_frame();
    for (int c = 0; c < CHANNELS; c++) begin
      for (int d = 0; d < CHAIN; d++) begin
        logic [AW-1:0] a;
        logic [15:0]   w;
        a = AW'(c*CHAIN + CHAIN - 1 - d);
        w = mem[a];
        exp_addr_q.push_back(a);
        for (int b = 15; b >= 0; b--)
          exp_q.push_back({w[b], 1'((d == CHAIN-1) && (b < DATA_LE))});
      end
    end
    repeat (2)        exp_q.push_back(2'b00);
    repeat (VSYNC_LE) exp_q.push_back(2'b01);
  endtask

  task automatic model_cfg(input logic [15:0] w);
    for (int c = 0; c < CHAIN; c++)
      for (int b = 15; b >= 0; b--)
        exp_q.push_back({w[b], 1'((c == CHAIN-1) && (b < CFG_LE))});
  endtask

  task automatic clear_all();
    exp_q.delete();
    got_q.delete();
    exp_addr_q.delete();
    addr_q.delete();
    fd_cnt = 0;
  endtask

  task automatic compare(input string tag, input int exp_fd);
    check($sformatf("%s_nper", tag), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_per%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check($sformatf("%s_nrd", tag), 32'(addr_q.size()), 32'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < addr_q.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), 32'(addr_q[i]), 32'(exp_addr_q[i]));
    check($sformatf("%s_fdone", tag), 32'(fd_cnt), 32'(exp_fd));
    clear_all();
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse(input logic s, input logic c, input logic [15:0] w);
    @(negedge sys_clk);
    bus.start    = s;
    bus.cfg_req  = c;
    bus.cfg_word = w;
    @(negedge sys_clk);
    bus.start    = 1'b0;
    bus.cfg_req  = 1'b0;
    bus.cfg_word = 16'($urandom);
  endtask

  // Waits until busy has been low for 3 straight cycles; reports the number
  // of busy-low cycles seen before that final quiet stretch.
  task automatic wait_quiet(output int idle_cycles);
    int n = 0, low = 0, streak = 0;
    while (streak < 3 && n < BUDGET) begin
      @(negedge sys_clk);
      n++;
      if (!bus.busy) begin low++; streak++; end
      else streak = 0;
    end
    check("quiet_timeout", 32'(n >= BUDGET), 32'd0);
    idle_cycles = low - streak;
  endtask

  // ---------------- test sequence ----------------
  int idle;
  int n;
  int act;
  logic [15:0] w;

  initial begin
    bus.start    = 1'b0;
    bus.cfg_req  = 1'b0;
    bus.cfg_word = '0;
    bus.rd_data  = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hA500 + 16'(i);

    // Reset values
    repeat (4) @(negedge sys_clk);
    check("rst_pins",  32'({bus.dclk, bus.sdi, bus.le, bus.rd_en, bus.busy, bus.frame_done}), 32'd0);
    check("rst_addr",  32'(bus.rd_addr), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'd0);
    sys_rst_n = 1'b1;

    // Idle for 100 cycles with no activity
    act = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (bus.dclk || bus.sdi || bus.le || bus.busy || bus.rd_en) act++;
    end
    check("idle_quiet", 32'(act), 32'd0);
    check("idle_nrd",   32'(addr_q.size()), 32'd0);
    clear_all();

    // Directed frame: A500+addr, timed start-to-frame_done
    model_frame();
    pulse(1'b1, 1'b0, 16'h0);
    n = 1;
    while (!bus.frame_done && n < BUDGET) begin
      @(negedge sys_clk);
      n++;
    end
    check("frame_len", 32'(n), 32'(FRAME_LEN));
    wait_quiet(idle);
    compare("frame_a5", 1);

    // Directed config write
    model_cfg(16'h8C3F);
    pulse(1'b0, 1'b1, 16'h8C3F);
    wait_quiet(idle);
    compare("cfg_8c3f", 0);

    // Simultaneous cfg_req and start: config first, then frame
    w = 16'($urandom);
    model_cfg(w);
    model_frame();
    pulse(1'b1, 1'b1, w);
    wait_quiet(idle);
    check("both_gap", 32'(idle), 32'd1);
    compare("both", 1);

    // Three starts while busy give exactly one extra frame
    model_frame();
    model_frame();
    pulse(1'b1, 1'b0, 16'h0);
    repeat (3) begin
      repeat ($urandom_range(10, 60)) @(negedge sys_clk);
      pulse(1'b1, 1'b0, 16'h0);
    end
    wait_quiet(idle);
    check("multi_gap", 32'(idle), 32'd1);
    compare("multi_start", 2);

    // Pending config is served before pending start
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    w = 16'($urandom);
    model_frame();
    model_cfg(w);
    model_frame();
    pulse(1'b1, 1'b0, 16'h0);
    repeat (30) @(negedge sys_clk);
    pulse(1'b1, 1'b0, 16'h0);
    repeat (10) @(negedge sys_clk);
    pulse(1'b0, 1'b1, w);
    wait_quiet(idle);
    check("prio_gap", 32'(idle), 32'd2);
    compare("prio", 2);

    // Randomized frames and configs
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      repeat ($urandom_range(1, 20)) @(negedge sys_clk);
      if ($urandom_range(0, 1) == 1) begin
        w = 16'($urandom);
        model_cfg(w);
        pulse(1'b0, 1'b1, w);
        wait_quiet(idle);
        compare($sformatf("rnd_cfg%0d", it), 0);
      end
      model_frame();
      pulse(1'b1, 1'b0, 16'h0);
      wait_quiet(idle);
      compare($sformatf("rnd_frame%0d", it), 1);
    end

    // Reset in the middle of the second word
    for (int i = 0; i < 256; i++) mem[i] = 16'hA500 + 16'(i);
    pulse(1'b1, 1'b0, 16'h0);
    n = 0;
    while (got_q.size() < 16 + 7 && n < BUDGET) begin
      @(negedge sys_clk);
      n++;
    end
    check("mid_timeout", 32'(n >= BUDGET), 32'd0);
    #2 sys_rst_n = 1'b0;
    #1;
    check("mid_rst_pins", 32'({bus.dclk, bus.sdi, bus.le, bus.rd_en, bus.busy, bus.frame_done}), 32'd0);
    check("mid_rst_addr", 32'(bus.rd_addr), 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    clear_all();
    model_frame();
    pulse(1'b1, 1'b0, 16'h0);
    wait_quiet(idle);
    compare("post_rst", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbi5353_frame_ctrl.md
Name: mbi5353_frame_ctrl

Overview:
- Sequences the MBI5353 LED-driver serial chain: generates DCLK, SDI and LE from one system clock.
- Fetches 16-bit gray words from the frame buffer and shifts them channel by channel. Terminates each word with a data-latch LE pulse and each frame with a VSYNC LE command.
- Also issues configuration-register writes.
- Sits between the frame-buffer read port and the driver pins; replaces free-running DCLK division with a scheduled, gated DCLK.

Parameters:
- CHAIN, 4, number of cascaded MBI5353 devices.
- CHANNELS, 16, gray words per device per frame.
- HALF, 4, sys_clk cycles per DCLK half-period (min 2).
- DATA_LE, 1, DCLK periods LE is high at end of a data word.
- VSYNC_LE, 3, DCLK periods LE is high for VSYNC.
- CFG_LE, 4, DCLK periods LE is high at end of a config word.
- AW, 8, frame-buffer address width.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: transmit one frame.
- cfg_req  in  1  one-cycle pulse: write cfg_word to every device.
- cfg_word  in  16  configuration value, sampled at cfg_req.
- rd_addr  out  AW  frame-buffer read address.
- rd_en  out  1  read strobe.
- rd_data  in  16  read data, valid exactly 1 sys_clk after rd_en.
- dclk  out  1  driver shift clock.
- sdi  out  1  driver serial data.
- le  out  1  driver latch enable.
- busy  out  1  high from accepted request until return to IDLE.
- frame_done  out  1  one-cycle pulse after VSYNC completes.

Behaviour:
- Reset: all outputs 0 (dclk=0, sdi=0, le=0, rd_en=0, rd_addr=0, busy=0, frame_done=0), FSM=IDLE, pending flags cleared. Reset is asynchronous and takes effect mid-shift: pins go low immediately, no partial LE is completed.
- DCLK: when not IDLE, toggles every HALF sys_clk, starting low. Each data bit spans one DCLK period. dclk stays 0 in IDLE and between words.
- Pin timing: sdi and le change only coincident with the dclk falling transition, or the start of the period. They are stable across the rising edge.
- Bit order: 16 bits per word, MSB first.
- FSM states: IDLE, FETCH, SHIFT, GAP, VSYNC, CFG, DONE.
- IDLE:
  - cfg_req -> CFG (busy=1).
  - else start -> FETCH with ch=0, dev=0 (busy=1).
  - If both arrive in the same cycle, cfg runs first and start is latched pending.
- Requests while busy: start while busy is latched into a single pending flag (further starts are dropped). cfg_req while busy is likewise latched with its cfg_word. Pending cfg is served before pending start on return to IDLE.
- FETCH:
  - rd_en=1 for one cycle, rd_addr = ch*CHAIN + (CHAIN-1-dev), so the farthest device is shifted first.
  - The next cycle, rd_data loads into the shift register -> SHIFT.
  - Total FETCH cost is 2 sys_clk with dclk held low.
- SHIFT:
  - 16 DCLK periods.
  - le=1 for the final DATA_LE periods of the word only when dev==CHAIN-1 (last word of a channel); otherwise le=0.
  - After the word: dev++. When dev wraps, ch++ and dev=0. When ch wraps from CHANNELS-1 -> GAP, else -> FETCH.
- GAP: 2 DCLK periods with sdi=0, le=0 -> VSYNC.
- VSYNC: VSYNC_LE DCLK periods with le=1, sdi=0 -> DONE.
- CFG:
  - CHAIN consecutive 16-bit copies of the latched cfg_word, with no fetch.
  - le=1 for the last CFG_LE periods of the final copy only -> IDLE. No frame_done.
- DONE: frame_done=1 for 1 cycle, dclk=0, le=0 -> IDLE; busy drops in the same cycle as the IDLE transition.
- Counters: bit counter 4 bit, dev counter clog2(CHAIN), ch counter clog2(CHANNELS), half-period counter clog2(HALF). All counters wrap exactly at their terminal values, with no overflow past them.
- Frame length: CHAIN*CHANNELS*(32*HALF + 2) + (2+VSYNC_LE)*2*HALF + 1 sys_clk from start to frame_done, ±1.

Test Plan:
- Reset then idle: dclk, sdi, le, busy stay 0 for 100 cycles; no rd_en.
- Frame transfer (CHAIN=2, CHANNELS=2, HALF=2, memory word = 16'hA500 + addr):
  - rd_addr sequence is 1, 0, 3, 2.
  - Captured SDI bits on dclk rising edges are A501, A500, A503, A502.
  - le is high for exactly 1 period at the end of words 2 and 4.
  - 64 data DCLK periods, then 2 GAP periods, then le high for 3 periods; frame_done pulses once.
- Config write with cfg_word=16'h8C3F: two copies shifted; le high only during the last 4 DCLK periods; no rd_en; no frame_done.
- Simultaneous cfg_req and start in IDLE: config completes first, then the frame runs with no idle gap beyond 1 cycle. Three starts issued while busy produce exactly one extra frame.
- Reset mid-SHIFT (bit 7 of word 2): all outputs go 0 within the same cycle. A new start afterwards begins at rd_addr=1 with a clean first word.
